// File: rtl/stream_pattern_gen.sv
// AXI4-Stream test pattern generator: ramps, checkerboard or flat frames of IMG_WIDTH x IMG_HEIGHT 8-bit pixels.
// Define PATGEN_FRAME_CNT_EN to add a 16-bit frame_count output that counts completed frames.
module stream_pattern_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_WIDTH  = 512,
  parameter int IMG_HEIGHT = 512
) (
  input  logic                  axi_clk,
  input  logic                  axi_reset,
  input  logic                  start,
  input  logic [1:0]            pattern_sel,
  output logic                  m_axis_valid,
  output logic [DATA_WIDTH-1:0] m_axis_data,
  output logic                  m_axis_last,
  input  logic                  m_axis_ready,
  output logic                  busy,
  output logic                  frame_done
`ifdef PATGEN_FRAME_CNT_EN
  ,
  output logic [15:0]           frame_count
`endif
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int BEATS = IMG_WIDTH / LANES;
  localparam int XW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int YW    = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [XW-1:0] X_LAST = XW'(BEATS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_HEIGHT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [1:0]    pattern;

  logic          handshake;
  logic          x_end;
  logic          y_end;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_next;

  // Builds one beat; byte lane i carries pixel x*LANES+i of line y.
  function automatic logic [DATA_WIDTH-1:0] make_beat(input logic [XW-1:0] bx,
                                                      input logic [YW-1:0] by,
                                                      input logic [1:0]    sel);
    logic [DATA_WIDTH-1:0] beat;
    logic [31:0]           px;
    logic [31:0]           py;
    logic [7:0]            pix;
    beat = '0;
    py   = 32'(by);
    for (int i = 0; i < LANES; i++) begin
      px = 32'(bx) * 32'(LANES) + 32'(i);
      case (sel)
        2'd0:    pix = px[7:0];
        2'd1:    pix = py[7:0];
        2'd2:    pix = (px[3] ^ py[3]) ? 8'hFF : 8'h00;
        default: pix = 8'h80;
      endcase
      beat[i*8 +: 8] = pix;
    end
    return beat;
  endfunction

  always_comb begin
    handshake = m_axis_valid & m_axis_ready;
    x_end     = (x == X_LAST);
    y_end     = (y == Y_LAST);
    x_next    = x_end ? '0 : x + XW'(1);
    y_next    = x_end ? y + YW'(1) : y;
  end

  assign busy = (state == RUN);

  // Output registers always hold the beat at (x, y); they only move on a handshake.
  always_ff @(posedge axi_clk or posedge axi_reset) begin
    if (axi_reset) begin
      state        <= IDLE;
      x            <= '0;
      y            <= '0;
      pattern      <= 2'd0;
      m_axis_valid <= 1'b0;
      m_axis_data  <= '0;
      m_axis_last  <= 1'b0;
      frame_done   <= 1'b0;
`ifdef PATGEN_FRAME_CNT_EN
      frame_count  <= 16'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          frame_done <= 1'b0;
          if (start) begin
            state        <= RUN;
            x            <= '0;
            y            <= '0;
            pattern      <= pattern_sel;
            m_axis_valid <= 1'b1;
            m_axis_data  <= make_beat('0, '0, pattern_sel);
            m_axis_last  <= (X_LAST == '0);
          end
        end
        RUN: begin
          if (handshake) begin
            if (x_end && y_end) begin
              state        <= DONE;
              x            <= '0;
              y            <= '0;
              m_axis_valid <= 1'b0;
              m_axis_last  <= 1'b0;
              frame_done   <= 1'b1;
`ifdef PATGEN_FRAME_CNT_EN
              frame_count  <= frame_count + 16'd1;
`endif
            end else begin
              x           <= x_next;
              y           <= y_next;
              m_axis_data <= make_beat(x_next, y_next, pattern);
              m_axis_last <= (x_next == X_LAST);
            end
          end
        end
        DONE: begin
          frame_done <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stream_pattern_gen.sv
// Directed self-checking bench for stream_pattern_gen: one 16x4 instance for ramps/flat/reset,
// one 32x16 instance for the checkerboard.
module tb_stream_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;

  logic        start_a;
  logic [1:0]  sel_a;
  logic        ready_a;
  logic        valid_a;
  logic [31:0] data_a;
  logic        last_a;
  logic        busy_a;
  logic        done_a;

  logic        start_b;
  logic [1:0]  sel_b;
  logic        ready_b;
  logic        valid_b;
  logic [31:0] data_b;
  logic        last_b;
  logic        busy_b;
  logic        done_b;

`ifdef PATGEN_FRAME_CNT_EN
  logic [15:0] count_a;
  logic [15:0] count_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stream_pattern_gen #(.DATA_WIDTH(32), .IMG_WIDTH(16), .IMG_HEIGHT(4)) dut_a (
    .axi_clk      (clk),
    .axi_reset    (rst),
    .start        (start_a),
    .pattern_sel  (sel_a),
    .m_axis_valid (valid_a),
    .m_axis_data  (data_a),
    .m_axis_last  (last_a),
    .m_axis_ready (ready_a),
    .busy         (busy_a),
    .frame_done   (done_a)
`ifdef PATGEN_FRAME_CNT_EN
    ,
    .frame_count  (count_a)
`endif
  );

  stream_pattern_gen #(.DATA_WIDTH(32), .IMG_WIDTH(32), .IMG_HEIGHT(16)) dut_b (
    .axi_clk      (clk),
    .axi_reset    (rst),
    .start        (start_b),
    .pattern_sel  (sel_b),
    .m_axis_valid (valid_b),
    .m_axis_data  (data_b),
    .m_axis_last  (last_b),
    .m_axis_ready (ready_b),
    .busy         (busy_b),
    .frame_done   (done_b)
`ifdef PATGEN_FRAME_CNT_EN
    ,
    .frame_count  (count_b)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [1:0] sel, input logic rdy);
    start_a = s;
    sel_a   = sel;
    ready_a = rdy;
  endtask

  // Horizontal ramp for beat x of any line: bytes 4x+3 .. 4x.
  function automatic logic [31:0] ramp_beat(input int bx);
    return 32'h03020100 + 32'(bx) * 32'h04040404;
  endfunction

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int b;
    logic [31:0] exp_v;

    rst = 1'b1;
    applyStimulus(1'b0, 2'd0, 1'b1);
    start_b = 1'b0;
    sel_b   = 2'd0;
    ready_b = 1'b1;
    repeat (2) @(negedge clk);

    checkOutput("rst_valid", {31'd0, valid_a}, 32'd0);
    checkOutput("rst_data", data_a, 32'd0);
    checkOutput("rst_last", {31'd0, last_a}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("rst_done", {31'd0, done_a}, 32'd0);
`ifdef PATGEN_FRAME_CNT_EN
    checkOutput("rst_count", {16'd0, count_a}, 32'd0);
`endif

    // Horizontal ramp, ready always high, start raised on the release edge.
    rst = 1'b0;
    applyStimulus(1'b1, 2'd0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k == 0) start_a = 1'b0;
      checkOutput("t1_valid", {31'd0, valid_a}, 32'd1);
      checkOutput("t1_busy", {31'd0, busy_a}, 32'd1);
      checkOutput("t1_data", data_a, ramp_beat(k % 4));
      checkOutput("t1_last", {31'd0, last_a}, {31'd0, (k % 4) == 3});
    end
    @(negedge clk);
    checkOutput("t1_done", {31'd0, done_a}, 32'd1);
    checkOutput("t1_valid_off", {31'd0, valid_a}, 32'd0);
    checkOutput("t1_busy_off", {31'd0, busy_a}, 32'd0);
    @(negedge clk);
    checkOutput("t1_done_pulse", {31'd0, done_a}, 32'd0);

    // Vertical ramp with ready toggling; a pattern_sel change mid-frame must be ignored.
    applyStimulus(1'b1, 2'd1, 1'b1);
    b = 0;
    for (int c = 0; c < 31; c++) begin
      @(negedge clk);
      if (c == 0) begin
        start_a = 1'b0;
        sel_a   = 2'd2;
      end
      ready_a = ((c % 2) == 0);
      checkOutput("t2_valid", {31'd0, valid_a}, 32'd1);
      checkOutput("t2_data", data_a, 32'h01010101 * 32'(b / 4));
      checkOutput("t2_last", {31'd0, last_a}, {31'd0, (b % 4) == 3});
      if (ready_a) b++;
    end
    @(negedge clk);
    ready_a = 1'b1;
    checkOutput("t2_done", {31'd0, done_a}, 32'd1);
    checkOutput("t2_valid_off", {31'd0, valid_a}, 32'd0);
    @(negedge clk);

    // Constant pattern, start held high: back-to-back frames with a two-cycle gap.
    applyStimulus(1'b1, 2'd3, 1'b1);
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        checkOutput("t3_valid", {31'd0, valid_a}, 32'd1);
        checkOutput("t3_data", data_a, 32'h80808080);
      end
      @(negedge clk);
      checkOutput("t3_gap1_valid", {31'd0, valid_a}, 32'd0);
      checkOutput("t3_gap1_done", {31'd0, done_a}, 32'd1);
      @(negedge clk);
      checkOutput("t3_gap2_valid", {31'd0, valid_a}, 32'd0);
      checkOutput("t3_gap2_done", {31'd0, done_a}, 32'd0);
`ifdef PATGEN_FRAME_CNT_EN
      checkOutput("t3_count", {16'd0, count_a}, 32'(f + 1));
`endif
      if (f == 2) start_a = 1'b0;
    end
    @(negedge clk);
    checkOutput("t3_stopped", {31'd0, valid_a}, 32'd0);
    checkOutput("t3_idle_busy", {31'd0, busy_a}, 32'd0);

    // Reset mid-frame while beat 7 is stalled.
    applyStimulus(1'b1, 2'd0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) start_a = 1'b0;
      if (k == 7) ready_a = 1'b0;
      checkOutput("t4_data", data_a, ramp_beat(k % 4));
      checkOutput("t4_last", {31'd0, last_a}, {31'd0, (k % 4) == 3});
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("t4_rst_valid", {31'd0, valid_a}, 32'd0);
    checkOutput("t4_rst_busy", {31'd0, busy_a}, 32'd0);
    checkOutput("t4_rst_data", data_a, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ready_a = 1'b1;
    @(negedge clk);
    checkOutput("t4_no_resume", {31'd0, valid_a}, 32'd0);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checkOutput("t4_restart_valid", {31'd0, valid_a}, 32'd1);
    checkOutput("t4_restart_data", data_a, 32'h03020100);
`ifdef PATGEN_FRAME_CNT_EN
    checkOutput("t4_count_rst", {16'd0, count_a}, 32'd0);
`endif

    // Checkerboard on the 32x16 instance: 8 beats per line, 8-pixel tiles.
    start_b = 1'b1;
    sel_b   = 2'd2;
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      if (k == 0) start_b = 1'b0;
      exp_v = ((((k % 8) >> 1) & 1) ^ (((k / 8) >> 3) & 1)) != 0 ? 32'hFFFFFFFF : 32'h00000000;
      checkOutput("t5_valid", {31'd0, valid_b}, 32'd1);
      checkOutput("t5_data", data_b, exp_v);
      checkOutput("t5_last", {31'd0, last_b}, {31'd0, (k % 8) == 7});
    end
    @(negedge clk);
    checkOutput("t5_done", {31'd0, done_b}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
